// File: rtl/log_compress.sv
`default_nettype none
// ============================================================================
// Module   : log_compress
// Purpose  : Three-stage pipelined log2 compressor for unsigned linear
//            magnitudes. It produces a fixed-point log code of the form
//            e.f, where e is the leading-one index and f holds the bits
//            just below the leading one (Mitchell approximation). A
//            dynamic-range floor is then subtracted, clamping at zero.
//              S1 : capture the sample (a zero sample becomes 1)
//              S2 : leading-one detect, fraction extract, optional correction
//              S3 : floor subtract / clamp into the output register
//            All stages shift together on advance = !out_valid || out_ready.
//            Empty slots travel through the pipe as bubbles.
// Ports    : clk        in   clock, rising edge
//            reset_n    in   asynchronous active-low reset
//            in_valid   in   upstream sample valid
//            in_ready   out  sample accepted this cycle (equals advance)
//            data_in    in   DATA_WIDTH unsigned magnitude
//            out_valid  out  data_out valid
//            out_ready  in   downstream accepts data_out
//            data_out   out  OUT_WIDTH compressed log code
// Config   : define LOGC_MITCHELL_CORR_EN to add the 2-bit Mitchell
//            correction term, which saturates at the all-ones code.
// Revision : 1.0  initial release
// ============================================================================
module log_compress #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 4,
  parameter int OUT_WIDTH  = 8,   // must be $clog2(DATA_WIDTH) + FRAC_BITS
  parameter int FLOOR      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  data_out
);

  localparam int                 E_W       = $clog2(DATA_WIDTH);
  localparam logic [OUT_WIDTH:0] FLOOR_EXT = (OUT_WIDTH+1)'(FLOOR);

  logic                  advance;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH-1:0]  s2_log_q,   s2_log_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  data_out_q,  data_out_d;

  logic [E_W-1:0]        lead_idx;
  logic [FRAC_BITS-1:0]  frac;
  logic [OUT_WIDTH-1:0]  log_raw;
  logic [OUT_WIDTH-1:0]  log_s2;
  logic [OUT_WIDTH:0]    floor_diff;
  logic [OUT_WIDTH-1:0]  floored;

  // The whole pipe moves as one. A stalled output freezes every stage.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  // Leading-one detect: the highest set bit wins because it is scanned last.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_data_q[i]) lead_idx = E_W'(i);
    end
  end

  // FRAC_BITS zeros are appended below the sample. Shifting right by the
  // leading-one index leaves the bits under the MSB in the low positions.
  // Short samples are zero-padded on the right automatically.
  always_comb begin
    frac = FRAC_BITS'({s1_data_q, {FRAC_BITS{1'b0}}} >> lead_idx);
  end

  assign log_raw = {lead_idx, frac};

`ifdef LOGC_MITCHELL_CORR_EN
  // The correction is +1 when the top two fraction bits are 01 or 10.
  // Otherwise it is 0.
  logic [1:0]         corr_sel;
  logic               corr_bit;
  logic [OUT_WIDTH:0] corr_sum;

  always_comb begin
    corr_sel = frac[FRAC_BITS-1 -: 2];
    corr_bit = corr_sel[1] ^ corr_sel[0];
    corr_sum = {1'b0, log_raw} + {{OUT_WIDTH{1'b0}}, corr_bit};
    log_s2   = corr_sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : corr_sum[OUT_WIDTH-1:0];
  end
`else
  assign log_s2 = log_raw;
`endif

  // The subtraction is one bit wider. A set borrow bit means the result
  // went below the floor, so the output clamps to zero.
  always_comb begin
    floor_diff = {1'b0, s2_log_q} - FLOOR_EXT;
    floored    = floor_diff[OUT_WIDTH] ? '0 : floor_diff[OUT_WIDTH-1:0];
  end

  // Data registers load only behind a valid slot. A bubble moves its valid
  // bit but leaves the stale payload untouched.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_log_d    = s2_log_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_data_d = (data_in == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : data_in;
      end
      if (s1_valid_q) s2_log_d   = log_s2;
      if (s2_valid_q) data_out_d = floored;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_log_q    <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_log_q    <= s2_log_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_log_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_compress
// Purpose  : Self-checking bench for log_compress. There are two DUTs on
//            shared stimulus: FLOOR=0 and FLOOR=32. Each output is compared
//            against an arithmetic log2 reference model through a
//            scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_log_compress;

  localparam int DW  = 16;
  localparam int FB  = 4;
  localparam int OW  = 8;
  localparam int FL1 = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] data_in;
  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [OW-1:0] data_out0, data_out1;

  always #5 clk = ~clk;

  log_compress #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .OUT_WIDTH(OW), .FLOOR(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .out_valid(out_valid0), .out_ready(out_ready),
    .data_out(data_out0)
  );

  log_compress #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .OUT_WIDTH(OW), .FLOOR(FL1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .out_valid(out_valid1), .out_ready(out_ready),
    .data_out(data_out1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int out_cnt = 0;
  bit steady = 1'b0;

  typedef struct {
    int exp0;
    int exp1;
    int acc;
  } ent_t;
  ent_t sb[$];

  logic          stall_prev = 1'b0;
  logic [OW-1:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: log2 from arithmetic, not bit slicing.
  function automatic int model(input int d, input int fl);
    int x, e, f, l;
`ifdef LOGC_MITCHELL_CORR_EN
    int t;
`endif
    x = (d == 0) ? 1 : d;
    e = 0;
    while ((x / (2 ** (e + 1))) != 0) e++;
    f = ((x - 2 ** e) * (2 ** FB)) / (2 ** e);
    l = e * (2 ** FB) + f;
`ifdef LOGC_MITCHELL_CORR_EN
    t = f / (2 ** (FB - 2));
    if (t == 1 || t == 2) l = l + 1;
    if (l > 2 ** OW - 1) l = 2 ** OW - 1;
`endif
    l = l - fl;
    if (l < 0) l = 0;
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: runs at negedge. Handshakes seen here complete on the next posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready0, !out_valid0 || out_ready);
      check("dut1_sync", {out_valid1, in_ready1}, {out_valid0, in_ready0});
      if (stall_prev) check("stall_hold", data_out0, held);
      if (in_valid && in_ready0) begin : push
        ent_t ne;
        ne.exp0 = model(int'(data_in), 0);
        ne.exp1 = model(int'(data_in), FL1);
        ne.acc  = cyc;
        sb.push_back(ne);
      end
      if (out_valid0 && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid0, 0);
        end else begin : pop
          ent_t e;
          e = sb.pop_front();
          check("data0", data_out0, e.exp0);
          check("data1", data_out1, e.exp1);
          if (steady) check("latency", cyc - e.acc, 3);
          out_cnt++;
        end
      end
      stall_prev = out_valid0 && !out_ready;
      held       = data_out0;
    end
  end

  task automatic step(output bit fire);
    @(negedge clk);
    fire = in_valid && in_ready0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] dv [6];
  int            de0[6];
  int            de1[6];

  initial begin
    bit f;
    logic [DW-1:0] cur;
    int sent;
    dv = '{16'h0000, 16'h0001, 16'h0006, 16'h8000, 16'hFFFF, 16'h0003};
`ifdef LOGC_MITCHELL_CORR_EN
    de0 = '{0, 0, 41, 240, 255, 25};
    de1 = '{0, 0, 9, 208, 223, 0};
`else
    de0 = '{0, 0, 40, 240, 255, 24};
    de1 = '{0, 0, 8, 208, 223, 0};
`endif
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid0, 0);
    check("rst_data_out", data_out0, 0);
    reset_n = 1'b1;
    check("rst_in_ready", in_ready0, 1);

    // Directed single samples, including the edge cases.
    steady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; data_in = dv[i];
      step(f);
      check("dir_accept", f, 1);
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (out_valid0) break;
        step(f);
      end
      check("dir_valid", out_valid0, 1);
      check("dir_out0", data_out0, de0[i]);
      check("dir_out1", data_out1, de1[i]);
      step(f);
    end

    // Back-pressure: 10 samples, with out_ready low for 5 cycles.
    steady = 1'b0; out_cnt = 0; sent = 0;
    cur = 16'($urandom);
    for (int c = 0; c < 30; c++) begin
      in_valid  = (sent < 10);
      data_in   = cur;
      out_ready = !(c >= 4 && c < 9);
      step(f);
      if (f) begin
        sent++;
        cur = 16'($urandom) >> $urandom_range(0, 15);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", out_cnt, 10);

    // Full throughput: 64 back-to-back samples.
    steady = 1'b1; out_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      data_in  = 16'($urandom) >> $urandom_range(0, 15);
      step(f);
      check("tp_accept", f, 1);
    end
    in_valid = 1'b0;
    repeat (4) step(f);
    check("tp_count", out_cnt, 64);
    steady = 1'b0;

    // Random valid and ready traffic.
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = 16'($urandom) >> $urandom_range(0, 15);
      step(f);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step(f);
    check("rand_drain", sb.size(), 0);

    // Reset while three samples are in flight, with the output stalled.
    out_ready = 1'b0;
    data_in = 16'h8000; in_valid = 1'b1; step(f);
    data_in = 16'h1234; step(f);
    data_in = 16'hFFFF; step(f);
    in_valid = 1'b0;
    check("pre_rst_full", out_valid0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid0, 0);
    check("async_rst_data", data_out0, 0);
    check("async_rst_valid1", out_valid1, 0);
    check("async_rst_data1", data_out1, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("post_rst_ready", in_ready0, 1);
    out_ready = 1'b1; out_cnt = 0;
    repeat (10) step(f);
    check("no_stale", out_cnt, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
